// File: rtl/divider_sequencer_pkg.sv
// Shared types and constants for the divider sequencer: FSM states,
// default operand width and the quotient reported on a zero divisor.
package divider_sequencer_pkg;

    localparam int DEF_NUM_BITS = 24;

    localparam logic [DEF_NUM_BITS-1:0] DZ_QUOTIENT = {DEF_NUM_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/divider_sequencer_if.sv
// Bundle of the two requester handshakes plus the divider-core control/data
// lines; the sequencer takes the slave view, the client/core side the master view.
interface divider_sequencer_if
    import divider_sequencer_pkg::*;
#(
    parameter int C_NUM_BITS = DEF_NUM_BITS
);
    logic                  req0_v;
    logic [C_NUM_BITS-1:0] req0_a;
    logic [C_NUM_BITS-1:0] req0_b;
    logic                  req0_rdy;
    logic                  rsp0_v;
    logic [C_NUM_BITS-1:0] rsp0_q;
    logic                  rsp0_dz;
    logic                  rsp0_ack;

    logic                  req1_v;
    logic [C_NUM_BITS-1:0] req1_a;
    logic [C_NUM_BITS-1:0] req1_b;
    logic                  req1_rdy;
    logic                  rsp1_v;
    logic [C_NUM_BITS-1:0] rsp1_q;
    logic                  rsp1_dz;
    logic                  rsp1_ack;

    logic                  div_ld;
    logic                  div_e;
    logic [C_NUM_BITS-1:0] div_a;
    logic [C_NUM_BITS-1:0] div_b;
    logic [C_NUM_BITS-1:0] div_q;
    logic                  busy;

    modport slave (
        input  req0_v, req0_a, req0_b, rsp0_ack,
        input  req1_v, req1_a, req1_b, rsp1_ack,
        input  div_q,
        output req0_rdy, rsp0_v, rsp0_q, rsp0_dz,
        output req1_rdy, rsp1_v, rsp1_q, rsp1_dz,
        output div_ld, div_e, div_a, div_b, busy
    );

    modport master (
        output req0_v, req0_a, req0_b, rsp0_ack,
        output req1_v, req1_a, req1_b, rsp1_ack,
        output div_q,
        input  req0_rdy, rsp0_v, rsp0_q, rsp0_dz,
        input  req1_rdy, rsp1_v, rsp1_q, rsp1_dz,
        input  div_ld, div_e, div_a, div_b, busy
    );

endinterface

// File: rtl/divider_sequencer_rr_arbiter_2.sv
// Two-way round-robin readiness: a requester is offered the slot unless the
// other one is also asking and was not the most recently served.
module rr_arbiter_2 (
    input  logic req0_v,
    input  logic req1_v,
    input  logic last_served,
    input  logic enable,
    output logic gnt0,
    output logic gnt1
);

    // gntn deliberately ignores reqn_v so readiness never waits on its own valid
    assign gnt0 = enable & (~req1_v | last_served);
    assign gnt1 = enable & (~req0_v | ~last_served);

endmodule

// File: rtl/divider_sequencer.sv
// Shares one iterative divider core between two requesters: arbitrates,
// latches operands, sequences load/enable for C_STEPS cycles and returns the quotient.
module divider_sequencer
    import divider_sequencer_pkg::*;
#(
    parameter int C_NUM_BITS = DEF_NUM_BITS,
    parameter int C_STEPS    = 24,
    parameter int C_CNT_W    = 5
) (
    input  logic                 CK,
    input  logic                 R,
    divider_sequencer_if.slave   bus
);

    state_t                state_r, next_state_s;
    logic [C_CNT_W-1:0]    cnt_r;
    logic                  last_served_r, owner_r, next_owner_s;
    logic                  gnt0_s, gnt1_s, acc0_s, acc1_s, acc_s;
    logic [C_NUM_BITS-1:0] sel_a_s, sel_b_s;
    logic                  sel_dz_s, ack_s, last_step_s;
    logic                  res_we_s, res_sel_s, res_dz_s;
    logic [C_NUM_BITS-1:0] res_q_s;
    logic                  div_ld_r, div_e_r, busy_r, rsp0_v_r, rsp1_v_r;
    logic [C_NUM_BITS-1:0] div_a_r, div_b_r, rsp0_q_r, rsp1_q_r;
    logic                  rsp0_dz_r, rsp1_dz_r;

    rr_arbiter_2 u_arb (
        .req0_v      (bus.req0_v),
        .req1_v      (bus.req1_v),
        .last_served (last_served_r),
        .enable      ((state_r == ST_IDLE) & ~R),
        .gnt0        (gnt0_s),
        .gnt1        (gnt1_s)
    );

    // Accept decode, operand select and result-write steering
    always_comb begin
        acc0_s      = gnt0_s & bus.req0_v;
        acc1_s      = gnt1_s & bus.req1_v;
        acc_s       = acc0_s | acc1_s;
        sel_a_s     = acc1_s ? bus.req1_a : bus.req0_a;
        sel_b_s     = acc1_s ? bus.req1_b : bus.req0_b;
        sel_dz_s    = (sel_b_s == {C_NUM_BITS{1'b0}});
        ack_s       = owner_r ? bus.rsp1_ack : bus.rsp0_ack;
        last_step_s = (cnt_r == C_CNT_W'(C_STEPS - 1));
        res_we_s    = (acc_s & sel_dz_s) | ((state_r == ST_RUN) & last_step_s);
        res_sel_s   = acc_s ? acc1_s : owner_r;
        res_q_s     = acc_s ? DZ_QUOTIENT : bus.div_q;
        res_dz_s    = acc_s;
    end

    // Next-state and next-owner logic
    always_comb begin
        next_state_s = state_r;
        next_owner_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    next_owner_s = acc1_s;
                    next_state_s = sel_dz_s ? ST_RESP : ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: next_state_s = ST_RUN;
            ST_RUN:  next_state_s = last_step_s ? ST_RESP : ST_RUN;
            ST_RESP: next_state_s = ack_s ? ST_IDLE : ST_RESP;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Control state, step counter and registered handshake/core-control outputs
    always_ff @(posedge CK) begin
        if (R) begin
            state_r       <= ST_IDLE;
            owner_r       <= 1'b0;
            last_served_r <= 1'b1;
            cnt_r         <= {C_CNT_W{1'b0}};
            div_ld_r      <= 1'b0;
            div_e_r       <= 1'b0;
            busy_r        <= 1'b0;
            rsp0_v_r      <= 1'b0;
            rsp1_v_r      <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            owner_r  <= next_owner_s;
            if (acc_s) begin
                last_served_r <= acc1_s;
            end
            cnt_r    <= (state_r == ST_RUN) ? cnt_r + C_CNT_W'(1) : {C_CNT_W{1'b0}};
            div_ld_r <= (next_state_s == ST_LOAD);
            div_e_r  <= (next_state_s == ST_LOAD) | (next_state_s == ST_RUN);
            busy_r   <= (next_state_s != ST_IDLE);
            rsp0_v_r <= (next_state_s == ST_RESP) & ~next_owner_s;
            rsp1_v_r <= (next_state_s == ST_RESP) & next_owner_s;
        end
    end

    // Operand latches and per-requester result registers (kept after ACK)
    always_ff @(posedge CK) begin
        if (R) begin
            div_a_r   <= {C_NUM_BITS{1'b0}};
            div_b_r   <= {C_NUM_BITS{1'b0}};
            rsp0_q_r  <= {C_NUM_BITS{1'b0}};
            rsp1_q_r  <= {C_NUM_BITS{1'b0}};
            rsp0_dz_r <= 1'b0;
            rsp1_dz_r <= 1'b0;
        end else begin
            if (acc_s) begin
                div_a_r <= sel_a_s;
                div_b_r <= sel_b_s;
            end
            if (res_we_s & ~res_sel_s) begin
                rsp0_q_r  <= res_q_s;
                rsp0_dz_r <= res_dz_s;
            end
            if (res_we_s & res_sel_s) begin
                rsp1_q_r  <= res_q_s;
                rsp1_dz_r <= res_dz_s;
            end
        end
    end

    assign bus.req0_rdy = gnt0_s;
    assign bus.req1_rdy = gnt1_s;
    assign bus.rsp0_v   = rsp0_v_r;
    assign bus.rsp1_v   = rsp1_v_r;
    assign bus.rsp0_q   = rsp0_q_r;
    assign bus.rsp1_q   = rsp1_q_r;
    assign bus.rsp0_dz  = rsp0_dz_r;
    assign bus.rsp1_dz  = rsp1_dz_r;
    assign bus.div_ld   = div_ld_r;
    assign bus.div_e    = div_e_r;
    assign bus.div_a    = div_a_r;
    assign bus.div_b    = div_b_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer with a step-counting divider core model.
module tb_divider_sequencer;
    import divider_sequencer_pkg::*;

    localparam int NB    = 24;
    localparam int STEPS = 24;

    logic CK = 1'b0;
    logic R  = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CK = ~CK;

    divider_sequencer_if #(.C_NUM_BITS(NB)) bus();

    divider_sequencer #(.C_NUM_BITS(NB), .C_STEPS(STEPS), .C_CNT_W(5)) dut (
        .CK  (CK),
        .R   (R),
        .bus (bus)
    );

    // Core model: quotient is only valid after exactly STEPS-1 enabled steps past the load
    logic [NB-1:0] m_a, m_b;
    int            m_steps = 0;
    always @(posedge CK) begin
        if (bus.div_ld) begin
            m_a     <= bus.div_a;
            m_b     <= bus.div_b;
            m_steps <= 0;
        end else if (bus.div_e) begin
            m_steps <= m_steps + 1;
        end
    end
    assign bus.div_q = (m_steps == STEPS - 1 && m_b != 24'd0) ? m_a / m_b : 24'h5A5A5A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #2;
    endtask

    // Sample from the cycle after the accept edge until the response shows up
    task automatic observe(input int who, input int maxc, output int lat,
                           output int n_ld, output int n_e, output int n_other);
        lat = -1; n_ld = 0; n_e = 0; n_other = 0;
        for (int k = 1; k <= maxc; k++) begin
            n_ld += int'(bus.div_ld);
            n_e  += int'(bus.div_e);
            if ((who == 0) ? bus.rsp1_v : bus.rsp0_v) n_other++;
            if ((who == 0) ? bus.rsp0_v : bus.rsp1_v) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    task automatic do_ack(input int who, input logic [NB-1:0] expq);
        if (who == 0) bus.rsp0_ack = 1'b1; else bus.rsp1_ack = 1'b1;
        tick();
        bus.rsp0_ack = 1'b0;
        bus.rsp1_ack = 1'b0;
        chk("ack_v_drop", 32'((who == 0) ? bus.rsp0_v : bus.rsp1_v), 32'd0);
        chk("ack_q_keep", 32'((who == 0) ? bus.rsp0_q : bus.rsp1_q), 32'(expq));
    endtask

    initial begin
        int lat, nld, ne, noth;
        logic [NB-1:0] expq;
        int exp_who;
        bus.req0_v = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.rsp0_ack = 1'b0;
        bus.req1_v = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.rsp1_ack = 1'b0;
        R = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rdy0", 32'(bus.req0_rdy), 32'd0);
        chk("rst_v0", 32'(bus.rsp0_v), 32'd0);
        chk("rst_v1", 32'(bus.rsp1_v), 32'd0);
        chk("rst_ld", 32'(bus.div_ld), 32'd0);
        chk("rst_e", 32'(bus.div_e), 32'd0);
        chk("rst_diva", 32'(bus.div_a), 32'd0);
        chk("rst_q0", 32'(bus.rsp0_q), 32'd0);
        chk("rst_dz1", 32'(bus.rsp1_dz), 32'd0);
        R = 1'b0;

        // 100/7 from requester 0 alone
        bus.req0_v = 1'b1; bus.req0_a = 24'd100; bus.req0_b = 24'd7;
        #1;
        chk("t1_rdy0", 32'(bus.req0_rdy), 32'd1);
        tick();
        bus.req0_v = 1'b0;
        observe(0, 40, lat, nld, ne, noth);
        chk("t1_lat", 32'(lat), 32'd26);
        chk("t1_nld", 32'(nld), 32'd1);
        chk("t1_ne", 32'(ne), 32'd25);
        chk("t1_v1", 32'(noth), 32'd0);
        chk("t1_q", 32'(bus.rsp0_q), 32'd14);
        chk("t1_dz", 32'(bus.rsp0_dz), 32'd0);
        do_ack(0, 24'd14);

        // Both valid out of reset: 0 first, 1 next; ACK held off for 5 cycles
        R = 1'b1;
        bus.req0_v = 1'b1; bus.req0_a = 24'd1000; bus.req0_b = 24'd10;
        bus.req1_v = 1'b1; bus.req1_a = 24'd81;   bus.req1_b = 24'd9;
        tick(); tick();
        R = 1'b0;
        #1;
        chk("t2_rdy0", 32'(bus.req0_rdy), 32'd1);
        chk("t2_rdy1", 32'(bus.req1_rdy), 32'd0);
        tick();
        bus.req0_v = 1'b0;
        observe(0, 40, lat, nld, ne, noth);
        chk("t2_lat0", 32'(lat), 32'd26);
        chk("t2_q0", 32'(bus.rsp0_q), 32'd100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_v", 32'(bus.rsp0_v), 32'd1);
            chk("t2_hold_q", 32'(bus.rsp0_q), 32'd100);
        end
        do_ack(0, 24'd100);
        chk("t2_rdy1b", 32'(bus.req1_rdy), 32'd1);
        tick();
        bus.req1_v = 1'b0;
        observe(1, 40, lat, nld, ne, noth);
        chk("t2_lat1", 32'(lat), 32'd26);
        chk("t2_v0", 32'(noth), 32'd0);
        chk("t2_q1", 32'(bus.rsp1_q), 32'd9);
        do_ack(1, 24'd9);

        // 50/0 from requester 1: divide-by-zero short path
        bus.req1_v = 1'b1; bus.req1_a = 24'd50; bus.req1_b = 24'd0;
        #1;
        chk("t3_rdy1", 32'(bus.req1_rdy), 32'd1);
        tick();
        bus.req1_v = 1'b0;
        observe(1, 40, lat, nld, ne, noth);
        chk("t3_lat", 32'(lat), 32'd1);
        chk("t3_nld", 32'(nld), 32'd0);
        chk("t3_ne", 32'(ne), 32'd0);
        chk("t3_q", 32'(bus.rsp1_q), 32'hFFFFFF);
        chk("t3_dz", 32'(bus.rsp1_dz), 32'd1);
        do_ack(1, 24'hFFFFFF);

        // Both held valid over four operations: grants alternate 0,1,0,1
        bus.req0_v = 1'b1; bus.req0_a = 24'd20; bus.req0_b = 24'd4;
        bus.req1_v = 1'b1; bus.req1_a = 24'd21; bus.req1_b = 24'd7;
        for (int op = 0; op < 4; op++) begin
            exp_who = op % 2;
            expq = (exp_who == 0) ? 24'd5 : 24'd3;
            #1;
            chk("t4_idle", 32'(bus.busy), 32'd0);
            chk("t4_rdy0", 32'(bus.req0_rdy), 32'(exp_who == 0));
            chk("t4_rdy1", 32'(bus.req1_rdy), 32'(exp_who == 1));
            tick();
            chk("t4_busy", 32'(bus.busy), 32'd1);
            observe(exp_who, 40, lat, nld, ne, noth);
            chk("t4_lat", 32'(lat), 32'd26);
            chk("t4_q", 32'((exp_who == 0) ? bus.rsp0_q : bus.rsp1_q), 32'(expq));
            do_ack(exp_who, expq);
        end
        bus.req0_v = 1'b0;
        bus.req1_v = 1'b0;

        // Reset during RUN of 500/3 discards the operation
        bus.req0_v = 1'b1; bus.req0_a = 24'd500; bus.req0_b = 24'd3;
        tick();
        bus.req0_v = 1'b0;
        repeat (11) tick();
        R = 1'b1;
        tick();
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_e", 32'(bus.div_e), 32'd0);
        chk("t5_v0", 32'(bus.rsp0_v), 32'd0);
        R = 1'b0;
        observe(0, 30, lat, nld, ne, noth);
        chk("t5_noresp", 32'(lat), 32'hFFFFFFFF);
        bus.req0_v = 1'b1; bus.req0_a = 24'd9; bus.req0_b = 24'd3;
        #1;
        chk("t5_rdy0", 32'(bus.req0_rdy), 32'd1);
        tick();
        bus.req0_v = 1'b0;
        observe(0, 40, lat, nld, ne, noth);
        chk("t5_lat", 32'(lat), 32'd26);
        chk("t5_q", 32'(bus.rsp0_q), 32'd3);
        do_ack(0, 24'd3);

        // Stray ACK while idle/running is ignored; first-cycle ACK closes RESP at once
        bus.rsp0_ack = 1'b1;
        tick(); tick();
        chk("t6_stray_v", 32'(bus.rsp0_v), 32'd0);
        chk("t6_stray_busy", 32'(bus.busy), 32'd0);
        bus.req0_v = 1'b1; bus.req0_a = 24'd40; bus.req0_b = 24'd8;
        tick();
        bus.req0_v = 1'b0;
        observe(0, 40, lat, nld, ne, noth);
        chk("t6_lat", 32'(lat), 32'd26);
        chk("t6_q", 32'(bus.rsp0_q), 32'd5);
        tick();
        chk("t6_v_once", 32'(bus.rsp0_v), 32'd0);
        chk("t6_idle", 32'(bus.busy), 32'd0);
        chk("t6_q_keep", 32'(bus.rsp0_q), 32'd5);
        bus.rsp0_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/divider_sequencer.md
Name: divider_sequencer

Overview:
Control block that shares one iterative divider datapath between two requesters. It arbitrates round-robin between the requesters and latches the winner's dividend and divisor. It then loads the datapath, counts C_STEPS clock-enabled steps and captures the quotient. The result is returned to the winning requester over a valid/ack handshake. It sits between the client logic and the divider core, and owns that core's load and clock-enable inputs.

Parameters:
C_NUM_BITS, 24, operand and quotient width
C_STEPS, 24, datapath step cycles per division; must be at least 1
C_CNT_W, 5, step counter width; must satisfy 2**C_CNT_W > C_STEPS

Ports:
CK  input  1  clock, rising edge
R  input  1  reset, synchronous, active-high
REQ0_V  input  1  requester 0 has an operand pair
REQ0_A  input  C_NUM_BITS  requester 0 dividend
REQ0_B  input  C_NUM_BITS  requester 0 divisor
REQ0_RDY  output  1  requester 0 transfer accepted when REQ0_V and REQ0_RDY are both high
RSP0_V  output  1  requester 0 result valid
RSP0_Q  output  C_NUM_BITS  requester 0 quotient
RSP0_DZ  output  1  requester 0 divide-by-zero flag
RSP0_ACK  input  1  requester 0 consumes the result
REQ1_V, REQ1_A, REQ1_B, REQ1_RDY, RSP1_V, RSP1_Q, RSP1_DZ, RSP1_ACK  as for requester 0
DIV_LD  output  1  load DIV_A/DIV_B into the datapath
DIV_E  output  1  datapath clock enable
DIV_A  output  C_NUM_BITS  latched dividend
DIV_B  output  C_NUM_BITS  latched divisor
DIV_Q  input  C_NUM_BITS  datapath quotient
BUSY  output  1  high in every state except IDLE

Behaviour:
- Clock is CK; reset R is synchronous and active-high.
- While R is high at a clock edge:
  - state goes to IDLE; step counter is 0; last_served is 1, so requester 0 wins the first tie.
  - DIV_A, DIV_B, RSPn_Q are 0; all V, RDY, DZ, DIV_LD, DIV_E and BUSY outputs are 0.
  - Reset mid-operation discards the operation in flight; no response is issued.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - REQn_RDY = IDLE & ~R & (~REQm_V | last_served != n), where m is the other requester.
  - RDY depends only on the other requester's V, never on its own.
  - On an accept: latch A and B into DIV_A/DIV_B, record owner = n, set last_served = n.
  - Next state is RESP if B == 0, otherwise LOAD.
- Divide-by-zero path: the datapath is never enabled. Result is all-ones with DZ = 1. Latency from accept to RSP_V is 1 cycle.
- LOAD, one cycle: DIV_LD = 1, DIV_E = 1, counter cleared. Next state RUN.
- RUN:
  - DIV_E = 1 and the counter increments every cycle.
  - After C_STEPS RUN cycles (counter == C_STEPS-1 at the edge), DIV_Q is registered into the result and the state goes to RESP.
- RESP:
  - RSP<owner>_V = 1 and RSP<owner>_Q/DZ hold steady until an edge where RSP<owner>_ACK is high.
  - After that edge the state is IDLE.
  - The ACK may be high in the first RESP cycle.
  - The non-owner's RSP_V stays 0. ACKs while RSP_V is low are ignored.
- Normal latency: accept at edge t; RSP_V is high from cycle t+C_STEPS+2 (26 cycles at defaults).
- Throughput: the earliest next accept is in the IDLE cycle directly after the ACK edge.
- RSPn_Q keeps its last value after the ACK; only RSPn_V deasserts.
- Simultaneous REQ0_V and REQ1_V strictly alternate grants. A lone requester wins every time.
- A requester that drops V before it is accepted loses nothing.
- BUSY = (state != IDLE).

Decomposition:
- Package divider_sequencer_pkg holds:
  - the state enum (IDLE, LOAD, RUN, RESP);
  - the default C_NUM_BITS;
  - the divide-by-zero quotient constant (all-ones).
- Sub-module rr_arbiter_2: the 2-way round-robin grant logic.
  - Inputs: REQ0_V, REQ1_V, last_served, enable.
  - Outputs: gnt0, gnt1.
- Counter, FSM and result registers live in divider_sequencer.

Test Plan:
- Req0 100/7, req1 idle, bench divider model -> REQ0_RDY high in the same cycle; DIV_LD pulses once; DIV_E high 25 cycles; RSP0_V high 26 cycles after accept with RSP0_Q = 14, DZ = 0; RSP1_V stays 0.
- Both requesters valid from reset: req0 1000/10 and req1 81/9 -> req0 granted first, then req1; RSP0_Q = 100, then RSP1_Q = 9. With the ACK held low 5 cycles, RSP0_V and RSP0_Q are stable throughout.
- Req1 50/0 -> RSP1_V one cycle after accept, RSP1_Q = 0xFFFFFF, RSP1_DZ = 1; DIV_LD and DIV_E never assert.
- Both requesters held continuously valid over 4 operations -> grants go 0,1,0,1. After each ACK there is exactly one IDLE cycle before the next accept.
- R asserted during RUN (step 10) of 500/3 -> next cycle: IDLE, BUSY = 0, DIV_E = 0, no RSP_V. A following 9/3 returns 3.
- RSP0_ACK high while RSP0_V = 0, and ACK asserted in the first RESP cycle -> the stray ACK has no effect; the first-cycle ACK completes in one cycle (RSP0_V high exactly one cycle).
